decomp_stream_ctrl: RTL and testbench
=====================================

Name: decomp_stream_ctrl

Overview:
Sequences the frame-buffer decompressor. It pops RGB565-residual words from the compressed-stream FIFO (show-ahead) and issues exactly one decompressor request per displayed pixel during active video. Frame alignment is guaranteed by construction: every frame delivers exactly H_ACTIVE*V_ACTIVE requests, padding on underflow or early frame start, because the decompressor has no frame-start input and its internal row/col counters must stay aligned. Sits between the SDRAM read FIFO and the decompressor, paced by the VGA timing generator.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 600, active lines per frame
CNT_W, 16, width of the saturating status counters

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_frame_start  in  1  single-cycle pulse at the start of vertical blanking, from the timing generator
i_pix_en  in  1  display consumes one pixel; the timing generator leads the pixel by 2 cycles
i_fifo_data  in  16  show-ahead head word {R5,G6,B5 residual}
i_fifo_empty  in  1  FIFO empty
o_fifo_rd  out  1  pop the head word this cycle
o_dec_req  out  1  registered request to the decompressor
o_dec_data  out  16  registered residual to the decompressor
o_frame_done  out  1  pulse, cycle after the last request of a frame
o_frame_err  out  1  pulse on entry to FLUSH
o_underflow_cnt  out  CNT_W  saturating count of zero-padded pixels since reset
o_debt  out  10  words owed to be dropped; saturates at 1023
o_busy  out  1  high in STREAM or FLUSH

Behaviour:
- Reset values: all outputs 0; state ARM; pixel counter 0; debt 0.
- States: ARM -> STREAM on i_frame_start. STREAM -> ARM after issuing request number H*V, with o_frame_done pulsed the next cycle. STREAM -> FLUSH on i_frame_start when count < H*V. FLUSH -> ARM after count reaches H*V. The frame_start that caused FLUSH is consumed: one frame is dropped, and streaming resumes on the next i_frame_start.
- STREAM, i_pix_en=1, debt=0, FIFO not empty: o_fifo_rd=1 (combinational). Next cycle o_dec_req=1 and o_dec_data=head word.
- STREAM, i_pix_en=1, FIFO empty: no pop. Next cycle o_dec_req=1 and o_dec_data=0 (zero residual, so the decompressor outputs the prediction). Underflow count +1, saturating. Debt +1, saturating.
- Debt drop: when debt>0, i_pix_en=0 and the FIFO is not empty, pop without a request and decrement debt; any state except during reset. If i_pix_en=1 and debt>0 with the FIFO not empty: consume the word as a normal pixel (display has priority), and debt is unchanged.
- Debt at 1023 and a further underflow: debt stays 1023, o_frame_err pulses.
- FLUSH: o_dec_req=1 with data 0 on every cycle regardless of i_pix_en. No FIFO pops except debt drops. Underflow count is not incremented.
- i_frame_start in ARM is the normal start. In FLUSH it is ignored.
- Pixel counter: col 0..H-1, row 0..V-1. It increments on each issued o_dec_req and wraps to 0/0 after H*V.
- Latency: i_pix_en to o_dec_req is 1 cycle; decompressed pixel is valid 1 cycle later, so 2 cycles total.
- Async reset mid-frame clears everything to ARM. The decompressor shares i_rst_n, so both realign.

Decomposition:
- Package dec_ctrl_pkg: state enum {ARM, STREAM, FLUSH}; H_ACTIVE/V_ACTIVE defaults; RGB565 field-slice constants.
- Sub-module dec_pix_counter: col/row counter with advance input, last-pixel flag and wrap.

Test Plan:
- Reset (H=4, V=3): all outputs 0. Eight i_pix_en pulses in ARM -> no o_dec_req, no o_fifo_rd.
- Normal frame: FIFO holds 0x0001..0x000C; frame_start, then 12 i_pix_en pulses -> 12 pops. o_dec_req carries data 0x0001..0x000C, each 1 cycle after its i_pix_en. o_frame_done pulses once after the 12th. State returns to ARM.
- Underflow: FIFO empty at pixel 5 -> o_dec_data=0x0000 with o_dec_req=1, o_underflow_cnt=1, o_debt=1. Next idle cycle with the FIFO not empty -> one pop, no request, o_debt=0. Frame still totals 12 requests.
- Early frame_start after 7 requests -> o_frame_err pulse, then 5 consecutive zero-data requests, then ARM. Streaming restarts only on the following frame_start.
- Debt saturation: force 1024 underflows (H=64, V=32) -> o_debt=1023 and o_frame_err pulse on the 1024th. o_underflow_cnt=1024.
- Async reset asserted mid-STREAM at pixel 6 -> same-cycle clear of o_dec_req, o_fifo_rd and counters. After release, frame_start begins a full 12-request frame.

Source files
------------

// File: rtl/dec_ctrl_pkg.sv
// Shared types and constants for the frame-buffer decompressor stream controller.
// Holds the FSM state type, default raster size and the RGB565 residual field layout.
package dec_ctrl_pkg;

    typedef enum logic [1:0] {
        ARM,
        STREAM,
        FLUSH
    } state_t;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;

    localparam int PIX_W  = 16;
    localparam int DEBT_W = 10;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    function automatic logic [PIX_W-1:0] pack_rgb565(
        input logic [R_MSB-R_LSB:0] r,
        input logic [G_MSB-G_LSB:0] g,
        input logic [B_MSB-B_LSB:0] b
    );
        logic [PIX_W-1:0] w;
        w              = '0;
        w[R_MSB:R_LSB] = r;
        w[G_MSB:G_LSB] = g;
        w[B_MSB:B_LSB] = b;
        return w;
    endfunction

endpackage

// File: rtl/dec_pix_counter.sv
// Column/row position of the next request the decompressor will receive.
// Advances once per issued request and wraps to 0/0 after the last pixel of a frame.
module dec_pix_counter
    import dec_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_adv,
    output logic o_last
);

    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_end;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        col_end = (col_q == COL_LAST);
        o_last  = col_end && (row_q == ROW_LAST);
        if (i_adv) begin
            if (col_end) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/decomp_stream_ctrl.sv
// Feeds the decompressor exactly H_ACTIVE*V_ACTIVE requests per frame from the
// show-ahead residual FIFO, zero-padding on underflow and dropping owed words later.
module decomp_stream_ctrl
    import dec_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_pix_en,
    input  logic [PIX_W-1:0]  i_fifo_data,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd,
    output logic              o_dec_req,
    output logic [PIX_W-1:0]  o_dec_data,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic [CNT_W-1:0]  o_underflow_cnt,
    output logic [DEBT_W-1:0] o_debt,
    output logic              o_busy
);

    localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [PIX_W-1:0]   data_q, data_d;
    logic               last_req_q, last_req_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   uf_q, uf_d;
    logic [DEBT_W-1:0]  debt_q, debt_d;

    logic pix_slot;
    logic pop_pix;
    logic underflow;
    logic drop;
    logic adv;
    logic last_pix;

    dec_pix_counter #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE)
    ) u_pix_cnt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_adv  (adv),
        .o_last (last_pix)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        last_req_d = 1'b0;
        done_d     = last_req_q;
        debt_d     = debt_q;
        uf_d       = uf_q;

        pix_slot  = (state_q == STREAM) && i_pix_en;
        pop_pix   = pix_slot && !i_fifo_empty;
        underflow = pix_slot && i_fifo_empty;
        // Owed words are only dropped in cycles the display is not consuming one.
        drop      = (debt_q != '0) && !i_pix_en && !i_fifo_empty;
        o_fifo_rd = pop_pix || drop;

        req_d  = pix_slot || (state_q == FLUSH);
        adv    = req_d;
        data_d = pop_pix ? pack_rgb565(i_fifo_data[R_MSB:R_LSB],
                                       i_fifo_data[G_MSB:G_LSB],
                                       i_fifo_data[B_MSB:B_LSB]) : '0;

        if (underflow) begin
            if (debt_q == DEBT_MAX) begin
                err_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_W'(1);
            end
            if (uf_q != '1) begin
                uf_d = uf_q + CNT_W'(1);
            end
        end else if (drop) begin
            debt_d = debt_q - DEBT_W'(1);
        end

        // frame_done marks streamed frames only; a flushed frame is flagged by frame_err.
        case (state_q)
            ARM: begin
                if (i_frame_start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (adv && last_pix) begin
                    state_d    = ARM;
                    last_req_d = 1'b1;
                end else if (i_frame_start) begin
                    state_d = FLUSH;
                    err_d   = 1'b1;
                end
            end
            FLUSH: begin
                if (last_pix) begin
                    state_d = ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ARM;
            req_q      <= 1'b0;
            data_q     <= '0;
            last_req_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            uf_q       <= '0;
            debt_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            last_req_q <= last_req_d;
            done_q     <= done_d;
            err_q      <= err_d;
            uf_q       <= uf_d;
            debt_q     <= debt_d;
        end
    end

    assign o_dec_req       = req_q;
    assign o_dec_data      = data_q;
    assign o_frame_done    = done_q;
    assign o_frame_err     = err_q;
    assign o_underflow_cnt = uf_q;
    assign o_debt          = debt_q;
    assign o_busy          = (state_q == STREAM) || (state_q == FLUSH);

endmodule

// File: tb/tb_decomp_stream_ctrl.sv
// Bench for decomp_stream_ctrl: a 4x3 instance checked against a frame-level model,
// table vectors and directed sequences, plus a 64x32 instance for debt saturation.
module tb_decomp_stream_ctrl;

    localparam int H     = 4;
    localparam int V     = 3;
    localparam int FRAME = H * V;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pix_en;
    logic [15:0] fifo_data;
    logic        fifo_empty;

    logic        rd1, req1, done1, err1, busy1;
    logic [15:0] data1, uf1;
    logic [9:0]  debt1;
    logic        rd2, req2, done2, err2, busy2;
    logic [15:0] data2, uf2;
    logic [9:0]  debt2;

    always #5 clk = ~clk;

    decomp_stream_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_pix_en(pix_en),
        .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty), .o_fifo_rd(rd1),
        .o_dec_req(req1), .o_dec_data(data1), .o_frame_done(done1), .o_frame_err(err1),
        .o_underflow_cnt(uf1), .o_debt(debt1), .o_busy(busy1)
    );

    decomp_stream_ctrl #(.H_ACTIVE(64), .V_ACTIVE(32), .CNT_W(16)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_pix_en(pix_en),
        .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty), .o_fifo_rd(rd2),
        .o_dec_req(req2), .o_dec_data(data2), .o_frame_done(done2), .o_frame_err(err2),
        .o_underflow_cnt(uf2), .o_debt(debt2), .o_busy(busy2)
    );

    int total = 0;
    int bad   = 0;
    int req_seen;
    bit rd_seen;

    logic [15:0] q[$];
    bit          starve;

    // reference model of dut1: frame progress as a request count, debt/underflow as integers
    bit          m_active, m_flush, m_done_pend, m_rd;
    int          m_issued, m_debt, m_uf;
    bit          e_req, e_done, e_err, e_busy;
    logic [15:0] e_data;
    int          e_debt, e_uf;

    typedef struct {
        bit          fs;
        bit          pix;
        bit          rd;
        bit          req;
        logic [15:0] data;
        bit          done;
        bit          busy;
    } vec_t;
    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_flush = 0; m_done_pend = 0; m_rd = 0;
        m_issued = 0; m_debt = 0; m_uf = 0;
    endfunction

    function automatic void model_step(input bit fs, input bit pix, input bit empty,
                                       input logic [15:0] head);
        bit streaming, take, uf, drop, req;
        streaming = m_active && !m_flush;
        take      = streaming && pix && !empty;
        uf        = streaming && pix && empty;
        drop      = (m_debt > 0) && !pix && !empty;
        m_rd      = take || drop;
        req       = m_active && (m_flush || pix);
        e_err     = 0;
        e_done    = m_done_pend;
        m_done_pend = 0;
        if (uf) begin
            if (m_debt == 1023) e_err = 1;
            else m_debt++;
            if (m_uf < 65535) m_uf++;
        end else if (drop) begin
            m_debt--;
        end
        if (!m_active) begin
            m_active = fs;
        end else begin
            if (req) m_issued++;
            if (m_issued == FRAME) begin
                m_done_pend = !m_flush;
                m_active = 0; m_flush = 0; m_issued = 0;
            end else if (fs && !m_flush) begin
                m_flush = 1;
                e_err   = 1;
            end
        end
        e_req  = req;
        e_data = take ? head : 16'h0000;
        e_debt = m_debt;
        e_uf   = m_uf;
        e_busy = m_active;
    endfunction

    function automatic void drive_fifo();
        fifo_empty = starve || (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 16'hDEAD;
    endfunction

    task automatic step(input bit fs, input bit pix);
        frame_start = fs;
        pix_en      = pix;
        drive_fifo();
        #1;
        model_step(fs, pix, fifo_empty, fifo_data);
        rd_seen = rd1;
        chk("fifo_rd", rd1, m_rd);
        @(posedge clk);
        if (m_rd && q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        frame_start = 0;
        pix_en      = 0;
        drive_fifo();
        chk("dec_req", req1, e_req);
        chk("dec_data", data1, e_data);
        chk("frame_done", done1, e_done);
        chk("frame_err", err1, e_err);
        chk("underflow_cnt", uf1, e_uf);
        chk("debt", debt1, e_debt);
        chk("busy", busy1, e_busy);
        if (req1) req_seen++;
    endtask

    task automatic clean_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        int errs2;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        for (int k = 1; k <= 12; k++) begin
            tbl[2*k-1] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'(k), 1'b0, (k < 12)};
            tbl[2*k]   = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, (k == 12), (k < 12)};
        end

        rst_n = 1; frame_start = 0; pix_en = 0; starve = 0;
        drive_fifo();
        model_reset();
        #2 rst_n = 0;
        #10;
        chk("rst_rd", rd1, 0);       chk("rst_req", req1, 0);   chk("rst_data", data1, 0);
        chk("rst_done", done1, 0);   chk("rst_err", err1, 0);   chk("rst_uf", uf1, 0);
        chk("rst_debt", debt1, 0);   chk("rst_busy", busy1, 0);
        chk("rst2_rd", rd2, 0);      chk("rst2_req", req2, 0);  chk("rst2_done", done2, 0);
        chk("rst2_busy", busy2, 0);
        @(negedge clk);
        rst_n = 1;

        // pixel pulses while armed: nothing popped, nothing requested
        for (int k = 1; k <= 12; k++) q.push_back(16'(k));
        for (int i = 0; i < 8; i++) begin
            step(0, 1);
            chk("arm_rd", rd_seen, 0);
            chk("arm_req", req1, 0);
        end

        // normal frame from the vector table
        req_seen = 0;
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].fs, tbl[i].pix);
            chk("tbl_rd", rd_seen, tbl[i].rd);
            chk("tbl_req", req1, tbl[i].req);
            chk("tbl_data", data1, tbl[i].data);
            chk("tbl_done", done1, tbl[i].done);
            chk("tbl_busy", busy1, tbl[i].busy);
        end
        chk("tbl_req_total", req_seen, 12);

        // underflow on pixel 5, owed word dropped in the next idle cycle
        for (int k = 1; k <= 12; k++) q.push_back(16'h0100 + 16'(k));
        req_seen = 0;
        step(1, 0);
        for (int p = 1; p <= 4; p++) step(0, 1);
        starve = 1;
        step(0, 1);
        chk("uf_req", req1, 1);  chk("uf_data", data1, 16'h0000);
        chk("uf_cnt", uf1, 1);   chk("uf_debt", debt1, 1);
        starve = 0;
        step(0, 0);
        chk("drop_rd", rd_seen, 1); chk("drop_req", req1, 0); chk("drop_debt", debt1, 0);
        for (int p = 6; p <= 12; p++) begin
            step(0, 1);
            chk("post_drop_data", data1, 16'h0100 + 16'(p));
        end
        step(0, 0);
        chk("uf_frame_done", done1, 1);
        chk("uf_req_total", req_seen, 12);

        // early frame_start after 7 requests: flush 5 zero requests, drop the frame
        for (int k = 1; k <= 12; k++) q.push_back(16'h0200 + 16'(k));
        req_seen = 0;
        step(1, 0);
        for (int p = 1; p <= 7; p++) step(0, 1);
        step(1, 0);
        chk("flush_err", err1, 1); chk("flush_req0", req1, 0); chk("flush_busy", busy1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            chk("flush_req", req1, 1);
            chk("flush_data", data1, 16'h0000);
        end
        step(0, 0);
        chk("flush_end_req", req1, 0); chk("flush_end_busy", busy1, 0);
        chk("flush_req_total", req_seen, 12);
        step(0, 1);
        chk("post_flush_arm", req1, 0);
        step(1, 0);
        step(0, 1);
        chk("restart_req", req1, 1); chk("restart_data", data1, 16'h0208);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            while (q.size() < 4) q.push_back(16'($urandom));
            starve = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end
        starve = 0;

        // async reset in the middle of pixel 6
        clean_reset();
        q.delete();
        for (int k = 1; k <= 30; k++) q.push_back(16'h0300 + 16'(k));
        step(1, 0);
        for (int p = 1; p <= 5; p++) begin
            starve = (p == 3);
            step(0, 1);
        end
        starve = 0;
        chk("pre_rst_debt", debt1, 1);
        pix_en = 1;
        drive_fifo();
        #1;
        chk("pre_rst_rd", rd1, 1);
        rst_n = 0;
        #1;
        chk("arst_rd", rd1, 0);   chk("arst_req", req1, 0);  chk("arst_data", data1, 0);
        chk("arst_uf", uf1, 0);   chk("arst_debt", debt1, 0); chk("arst_busy", busy1, 0);
        pix_en = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        req_seen = 0;
        step(1, 0);
        for (int p = 1; p <= 12; p++) step(0, 1);
        step(0, 0);
        chk("arst_frame_done", done1, 1);
        chk("arst_req_total", req_seen, 12);

        // debt saturation on the 64x32 instance
        clean_reset();
        q.delete();
        starve = 1;
        step(1, 0);
        errs2 = 0;
        for (int n = 1; n <= 1024; n++) begin
            step(0, 1);
            if (n < 1024 && err2) errs2++;
            if (n == 1023) chk("sat_debt_1023", debt2, 1023);
        end
        chk("sat_early_err", errs2, 0);
        chk("sat_err", err2, 1);
        chk("sat_debt", debt2, 1023);
        chk("sat_uf", uf2, 1024);
        chk("sat_req", req2, 1);
        chk("sat_data", data2, 16'h0000);
        chk("sat_busy", busy2, 1);
        starve = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
